hv_core_pipe: RTL and testbench

//  Next-generation hypervector compute core. Holds a write-loaded item memory and executes a

---
 rtl/hv_core_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_hv_core_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_core_pipe.sv
// Hypervector compute core: write-loaded item memory, two-stage instruction pipeline
// (S1 accept + item read, S2 execute) and a buffered result FIFO carrying a last flag.
module hv_core_pipe #(
    parameter int DIM        = 1024,
    parameter int ITEM_DEPTH = 1024,
    parameter int NREG       = 4,
    parameter int OUT_DEPTH  = 2,
    localparam int AW        = $clog2(ITEM_DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           item_we,
    input  logic [AW-1:0]  item_waddr,
    input  logic [DIM-1:0] item_wdata,
    input  logic           inst_valid,
    output logic           inst_ready,
    input  logic [31:0]    inst_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DIM-1:0] res_data,
    output logic           res_last,
    output logic           busy,
    output logic           err
);

    localparam int SW = 2;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_PLOAD = 4'd2,
        OP_PERM  = 4'd3,
        OP_XORM  = 4'd4,
        OP_XORR  = 4'd5,
        OP_STORE = 4'd6,
        OP_COPY  = 4'd7,
        OP_LAST  = 4'd8,
        OP_CLEAR = 4'd9
    } op_e;

    // Valid/ready: a transfer happens on the rising edge where valid and ready are both
    // high; ready never depends on valid, and a valid side holds its data until accepted.

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_STORE) || (op == OP_LAST);
    endfunction

    // y[i] = x[(i+s) mod DIM]: the doubled word shifted right folds the wrap-around in.
    function automatic logic [DIM-1:0] rot(input logic [DIM-1:0] x, input logic [9:0] sh);
        logic [2*DIM-1:0] dbl;
        logic [31:0]      s;
        s   = 32'(sh) % 32'(DIM);
        dbl = {x, x} >> s;
        return dbl[DIM-1:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [DIM-1:0] item_mem [ITEM_DEPTH];
    logic [DIM-1:0] item_rdata;

    logic           s1_valid_q, s1_valid_d;
    logic [31:0]    s1_inst_q,  s1_inst_d;
    logic [DIM-1:0] s1_m_q,     s1_m_d;
    logic           s2_valid_q, s2_valid_d;
    logic [31:0]    s2_inst_q,  s2_inst_d;
    logic [DIM-1:0] s2_m_q,     s2_m_d;
    logic [DIM-1:0] acc_q,      acc_d;
    logic [DIM-1:0] regs_q [NREG];
    logic [DIM-1:0] regs_d [NREG];
    logic           err_q,      err_d;
    logic [DIM:0]   fifo_q [OUT_DEPTH];
    logic [DIM:0]   fifo_d [OUT_DEPTH];
    logic [PW-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]  count_q,    count_d;

    logic           inst_fire;
    logic [CW:0]    pending;
    logic           push, pop;
    logic [DIM:0]   push_data;
    logic [DIM:0]   head;

    logic [3:0]     ex_op;
    logic [SW-1:0]  ex_k;
    logic [9:0]     ex_sh;
    logic [15:0]    ex_addr;
    logic           addr_bad, k_bad;

    always_ff @(posedge clk) begin
        if (item_we) begin
            item_mem[item_waddr] <= item_wdata;
        end
    end

    assign item_rdata = item_mem[inst_data[AW-1:0]];

    // Results already queued plus stores still in the pipe reserve FIFO slots up front,
    // so the pipeline never has to stall on a full FIFO.
    always_comb begin
        pending = {1'b0, count_q}
                + (CW+1)'(s1_valid_q & is_store(s1_inst_q[31:28]))
                + (CW+1)'(s2_valid_q & is_store(s2_inst_q[31:28]));
    end

    assign inst_ready = rst_n & ~item_we & (pending < (CW+1)'(OUT_DEPTH));
    assign inst_fire  = inst_valid & inst_ready;

    always_comb begin
        s1_valid_d = inst_fire;
        s1_inst_d  = inst_fire ? inst_data  : s1_inst_q;
        s1_m_d     = inst_fire ? item_rdata : s1_m_q;
        s2_valid_d = s1_valid_q;
        s2_inst_d  = s1_inst_q;
        s2_m_d     = s1_m_q;
    end

    assign ex_op    = s2_inst_q[31:28];
    assign ex_k     = s2_inst_q[27:26];
    assign ex_sh    = s2_inst_q[25:16];
    assign ex_addr  = s2_inst_q[15:0];
    assign addr_bad = 32'(ex_addr) >= 32'(ITEM_DEPTH);
    assign k_bad    = 32'(ex_k) >= 32'(NREG);

    always_comb begin
        acc_d     = acc_q;
        regs_d    = regs_q;
        err_d     = err_q;
        push      = 1'b0;
        push_data = '0;
        if (s2_valid_q) begin
            case (ex_op)
                OP_NOP: begin
                end
                OP_LOAD: begin
                    if (addr_bad) err_d = 1'b1;
                    else          acc_d = s2_m_q;
                end
                OP_PLOAD: begin
                    if (addr_bad) err_d = 1'b1;
                    else          acc_d = rot(s2_m_q, ex_sh);
                end
                OP_PERM: acc_d = rot(acc_q, ex_sh);
                OP_XORM: begin
                    if (addr_bad) err_d = 1'b1;
                    else          acc_d = acc_q ^ s2_m_q;
                end
                OP_XORR: begin
                    if (k_bad) err_d = 1'b1;
                    else       acc_d = acc_q ^ regs_q[ex_k];
                end
                OP_STORE: begin
                    push      = 1'b1;
                    push_data = {acc_q, 1'b0};
                end
                OP_COPY: begin
                    if (k_bad) err_d = 1'b1;
                    else       regs_d[ex_k] = acc_q;
                end
                OP_LAST: begin
                    push      = 1'b1;
                    push_data = {acc_q, 1'b1};
                end
                OP_CLEAR: begin
                    acc_d = '0;
                    for (int i = 0; i < NREG; i++) begin
                        regs_d[i] = '0;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        pop      = (count_q != '0) & res_ready;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            s1_m_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_m_q     <= '0;
            acc_q      <= '0;
            regs_q     <= '{default: '0};
            err_q      <= 1'b0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_m_q     <= s1_m_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_m_q     <= s2_m_d;
            acc_q      <= acc_d;
            regs_q     <= regs_d;
            err_q      <= err_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign res_valid = (count_q != '0);
    assign res_data  = res_valid ? head[DIM:1] : '0;
    assign res_last  = res_valid & head[0];
    assign busy      = s1_valid_q | s2_valid_q | (count_q != '0);
    assign err       = err_q;

endmodule

// File: tb/tb_hv_core_pipe.sv
// Bench for hv_core_pipe: directed scenarios plus random instruction streams, results
// scoreboarded against a program-order model of the instruction set.
module tb_hv_core_pipe;
  localparam int DIM = 8;
  localparam int ITEM_DEPTH = 16;
  localparam int NREG = 4;
  localparam int OUT_DEPTH = 2;
  localparam int AW = 4;
  localparam int W = DIM + 1;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_PLOAD = 4'd2, OP_PERM = 4'd3,
                         OP_XORR = 4'd5, OP_STORE = 4'd6, OP_COPY = 4'd7,
                         OP_LAST = 4'd8;

  logic           clk;
  logic           rst_n;
  logic           item_we;
  logic [AW-1:0]  item_waddr;
  logic [DIM-1:0] item_wdata;
  logic           inst_valid;
  logic           inst_ready;
  logic [31:0]    inst_data;
  logic           res_valid;
  logic           res_ready;
  logic [DIM-1:0] res_data;
  logic           res_last;
  logic           busy;
  logic           err;

  hv_core_pipe #(
    .DIM(DIM), .ITEM_DEPTH(ITEM_DEPTH), .NREG(NREG), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .item_we(item_we), .item_waddr(item_waddr), .item_wdata(item_wdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int accept_cyc = 0;
  int ready_mode = 1;

  // reference model state
  logic [DIM-1:0] m_item [ITEM_DEPTH];
  logic [DIM-1:0] m_acc;
  logic [DIM-1:0] m_r [NREG];
  logic           m_err;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   exp_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DIM-1:0] ref_rot(input logic [DIM-1:0] x, input int unsigned sh);
    logic [DIM-1:0] y;
    int unsigned s;
    s = sh % DIM;
    for (int i = 0; i < DIM; i++) y[i] = x[(i + s) % DIM];
    return y;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] k,
                                     input logic [9:0] sh, input logic [15:0] a);
    return {op, k, sh, a};
  endfunction

  task automatic mdl_reset();
    m_acc = '0;
    for (int i = 0; i < NREG; i++) m_r[i] = '0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic mdl_apply(input logic [31:0] inst);
    logic [3:0]  op;
    logic [1:0]  k;
    logic [9:0]  sh;
    logic [15:0] a;
    bit          a_ok;
    bit          k_ok;
    logic [DIM-1:0] m;
    op = inst[31:28];
    k = inst[27:26];
    sh = inst[25:16];
    a = inst[15:0];
    a_ok = (int'(a) < ITEM_DEPTH);
    k_ok = (int'(k) < NREG);
    m = a_ok ? m_item[a[AW-1:0]] : '0;
    case (op)
      4'd0: ;
      4'd1: if (a_ok) m_acc = m; else m_err = 1'b1;
      4'd2: if (a_ok) m_acc = ref_rot(m, sh); else m_err = 1'b1;
      4'd3: m_acc = ref_rot(m_acc, sh);
      4'd4: if (a_ok) m_acc = m_acc ^ m; else m_err = 1'b1;
      4'd5: if (k_ok) m_acc = m_acc ^ m_r[k]; else m_err = 1'b1;
      4'd6: exp_q.push_back({m_acc, 1'b0});
      4'd7: if (k_ok) m_r[k] = m_acc; else m_err = 1'b1;
      4'd8: exp_q.push_back({m_acc, 1'b1});
      4'd9: begin
        m_acc = '0;
        for (int i = 0; i < NREG; i++) m_r[i] = '0;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic write_item(input logic [AW-1:0] a, input logic [DIM-1:0] d);
    item_we = 1'b1;
    item_waddr = a;
    item_wdata = d;
    m_item[a] = d;
    @(posedge clk);
    #1;
    item_we = 1'b0;
  endtask

  task automatic issue(input logic [31:0] inst);
    bit done;
    done = 1'b0;
    inst_valid = 1'b1;
    inst_data = inst;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (inst_ready) begin
        done = 1'b1;
        accept_cyc = cyc;
        mdl_apply(inst);
      end
    end
    check("issue_accepted", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    inst_data = '0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && (exp_q.size() == 0);
    end
    check("drain_idle", 32'(idle), 32'd1);
  endtask

  // result acceptance pattern
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: res_ready = 1'b0;
        1: res_ready = 1'b1;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      check("res_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(exp_w[W-1:1]));
        check("res_last", 32'(res_last), 32'(exp_w[0]));
      end
    end else if (res_valid) begin
      if (exp_q.size() != 0) check("res_hold", 32'({res_data, res_last}), 32'(exp_q[0]));
    end else begin
      check("res_idle_zero", 32'({res_data, res_last}), 32'd0);
    end
  end

  initial begin
    int lat;
    logic [3:0] op;
    rst_n = 1'b0;
    item_we = 1'b0;
    item_waddr = '0;
    item_wdata = '0;
    inst_valid = 1'b0;
    inst_data = '0;
    mdl_reset();
    repeat (3) @(negedge clk);
    check("rst_inst_ready", 32'(inst_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    sync();
    for (int i = 0; i < ITEM_DEPTH; i++) write_item(AW'(i), DIM'($urandom));

    // LOAD/STORE and latency from accept to res_valid
    write_item(4'd3, 8'hA5);
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd3));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = cyc - accept_cyc;
        break;
      end
    end
    check("store_latency", 32'(lat), 32'd3);
    sync();

    // PLOAD rotate, shift amount wraps modulo DIM
    write_item(4'd1, 8'h01);
    issue(mk(OP_PLOAD, 2'd0, 10'd1, 16'd1));
    issue(mk(OP_LAST, 2'd0, 10'd0, 16'd0));
    issue(mk(OP_PLOAD, 2'd0, 10'd9, 16'd1));
    issue(mk(OP_LAST, 2'd0, 10'd0, 16'd0));

    // register copy and XOR
    write_item(4'd2, 8'h0F);
    write_item(4'd5, 8'hF0);
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd2));
    issue(mk(OP_COPY, 2'd1, 10'd0, 16'd0));
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd5));
    issue(mk(OP_XORR, 2'd1, 10'd0, 16'd0));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    wait_idle();

    // backpressure: FIFO fills, instructions are held off, then everything drains in order
    sync();
    ready_mode = 0;
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd3));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    issue(mk(OP_PERM, 2'd0, 10'd1, 16'd0));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    repeat (5) @(negedge clk);
    check("full_inst_ready", 32'(inst_ready), 32'd0);
    check("full_res_valid", 32'(res_valid), 32'd1);
    check("full_busy", 32'(busy), 32'd1);
    sync();
    fork
      begin
        issue(mk(OP_PERM, 2'd0, 10'd1, 16'd0));
        issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
        issue(mk(OP_PERM, 2'd0, 10'd1, 16'd0));
        issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
      end
      begin
        repeat (6) @(posedge clk);
        ready_mode = 1;
      end
    join
    wait_idle();

    // item write takes priority over an offered instruction
    sync();
    item_we = 1'b1;
    item_waddr = 4'd7;
    item_wdata = 8'h3C;
    inst_valid = 1'b1;
    inst_data = mk(OP_STORE, 2'd0, 10'd0, 16'd0);
    @(negedge clk);
    check("we_priority_ready", 32'(inst_ready), 32'd0);
    @(posedge clk);
    #1;
    item_we = 1'b0;
    inst_valid = 1'b0;
    m_item[7] = 8'h3C;
    repeat (4) @(negedge clk);
    check("we_no_accept_busy", 32'(busy), 32'd0);
    sync();
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd7));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    wait_idle();

    // illegal opcode: sticky error, accumulator untouched
    sync();
    issue(mk(4'd12, 2'd0, 10'd0, 16'd0));
    repeat (4) @(negedge clk);
    check("err_illegal_op", 32'(err), 32'd1);
    sync();
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    wait_idle();

    // reset mid-stream discards everything in flight
    sync();
    ready_mode = 0;
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd2));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_out", 32'({res_data, res_last}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_inst_ready", 32'(inst_ready), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    mdl_reset();
    ready_mode = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync();
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));

    // out-of-range item address
    issue(mk(OP_LOAD, 2'd0, 10'd0, 16'd20));
    repeat (4) @(negedge clk);
    check("err_bad_addr", 32'(err), 32'd1);
    sync();
    issue(mk(OP_STORE, 2'd0, 10'd0, 16'd0));
    wait_idle();

    // random instruction stream with random item writes and result backpressure
    sync();
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) write_item(AW'($urandom_range(0, ITEM_DEPTH - 1)), DIM'($urandom));
      if ($urandom_range(0, 99) < 4) op = 4'($urandom_range(10, 15));
      else op = 4'($urandom_range(0, 9));
      issue(mk(op, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)),
               16'($urandom_range(0, 19))));
    end
    ready_mode = 1;
    wait_idle();
    check("final_err", 32'(err), 32'(m_err));
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
